uart_tx_feeder: RTL and testbench
=================================

# uart_tx_feeder

Transmit-side buffer and launcher that sits directly upstream of the UART transmitter. It accepts bytes from the processor/bus side into a FIFO, hands them one at a time to the transmitter via the `tx_start`/`din` strobe, and waits for the transmitter's `tx_done_tick` before launching the next byte. This decouples software write bursts from the serial bit rate.

## Interface
- `DBIT`, default 8: data width, matching the transmitter.
- `ADDR_W`, default 4: FIFO address width; depth = 2^ADDR_W (16).

- `clk` in 1: system clock, shared with the transmitter.
- `reset` in 1: asynchronous, active-high reset; clears all state.
- `wr` in 1: write strobe; one byte is pushed per cycle with `wr`=1.
- `w_data` in DBIT: byte to push, sampled when `wr`=1.
- `full` out 1: FIFO holds 2^ADDR_W entries.
- `empty` out 1: FIFO holds 0 entries.
- `count` out ADDR_W+1: current FIFO occupancy, 0..2^ADDR_W.
- `overflow` out 1: one-cycle pulse when a write is dropped because the FIFO is full.
- `tx_start` out 1: one-cycle launch pulse to the transmitter.
- `tx_din` out DBIT: byte for the transmitter; stable from `tx_start` until the next launch.
- `tx_done_tick` in 1: transmitter completion pulse, end of stop bit.
- `busy` out 1: `(state != IDLE) | !empty`.

## Operation
- FIFO: circular buffer, `wr_ptr`/`rd_ptr` of ADDR_W bits wrap naturally at 2^ADDR_W; `count` register of ADDR_W+1 bits; `full`/`empty` decoded from `count`.
- Push: `wr`=1 and !`full` → mem[`wr_ptr`] ← `w_data`, `wr_ptr`++.
- `wr`=1 and `full` → data dropped, pointers unchanged, `overflow`=1 next cycle. A pop in the same cycle does not rescue the write.
- Launcher FSM, 3 states:
  - IDLE: if !`empty`: `tx_din` ← mem[`rd_ptr`], `rd_ptr`++, go START. Otherwise stay.
  - START: `tx_start`=1 (decoded from state). Go WAIT unconditionally.
  - WAIT: on `tx_done_tick`=1 go IDLE. Otherwise stay.
- `tx_done_tick` is ignored in IDLE and START.
- `count` update:
  - push only → +1
  - pop only → −1
  - push and pop together, FIFO neither full nor empty → unchanged
  - push into empty FIFO → +1; the pop decision uses the registered `empty`, so the byte is not popped in the same cycle.
- Reset (async, any time including mid-frame):
  - state=IDLE, pointers=0, `count`=0, `empty`=1, `full`=0, `tx_start`=0, `tx_din`=0, `overflow`=0, `busy`=0.
  - FIFO contents are lost. The transmitter is reset by the same `reset`.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from `wr` or `tx_done_tick` to any output.
- Latency: `wr` sampled at edge k into an empty FIFO with the FSM in IDLE:
  - `count`=1 after edge k
  - FSM enters START at edge k+1; `tx_start`=1 for exactly the cycle following edge k+1
  - `tx_din` is valid in that same cycle
- Back-to-back: `tx_done_tick` sampled at edge m → IDLE at m; START at m+1 if FIFO non-empty. The transmitter (idle after m) samples `tx_start` at edge m+2.
- Minimum inter-launch spacing is 3 cycles. Actual spacing is set by frame length.
- `tx_start` is never asserted twice without an intervening `tx_done_tick`.

## Test plan
- Reset: assert `reset` asynchronously mid-WAIT with `count`=5 → immediately `tx_start`=0, `count`=0, `empty`=1, `busy`=0. After release, no launch until a new write.
- Single byte: write 0xA5 at edge k → `tx_start` pulse after edge k+1 with `tx_din`=0xA5. No second pulse until `tx_done_tick`; afterwards `busy`=0.
- Burst: write 0x00..0x0F on 16 consecutive cycles while the transmitter (DBIT=8, SB_TICK=16) runs.
  - `full` is never asserted, because the first byte pops.
  - The serial line carries 0x00..0x0F in order, each with start/stop bits.
  - Exactly 16 `tx_start` pulses.
- Overflow: hold `tx_done_tick`=0, write 18 bytes.
  - One byte is popped; `count` reaches 16 with `full`=1.
  - The 18th write produces an `overflow` pulse and is dropped; `count` stays 16.
- Pointer wrap: push/pop 40 bytes with random `wr` gaps and random-length transmitter frames → output order equals input order across multiple `rd_ptr`/`wr_ptr` wraps; `count` matches the scoreboard every cycle.
- Simultaneous push/pop: with `count`=3, assert `wr` in the same cycle the FSM pops from IDLE → `count` stays 3 and the pushed byte is transmitted fourth.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Transmit FIFO and launcher in front of the UART transmitter: buffers bus writes
// and hands one byte at a time to the transmitter, waiting for its done tick.
module uart_tx_feeder #(
   parameter int DBIT   = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic [DBIT-1:0]   w_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              tx_start,
   output logic [DBIT-1:0]   tx_din,
   input  logic              tx_done_tick,
   output logic              busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                overflow_q, overflow_d;
   logic [DBIT-1:0]     tx_din_q, tx_din_d;
   logic [DBIT-1:0]     mem [DEPTH];

   logic                push;
   logic                pop;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   // Pop decision looks only at registered occupancy, so a byte written into an
   // empty FIFO is launched one cycle later rather than in the same cycle.
   assign push = wr & ~full;
   assign pop  = (state_q == IDLE) & ~empty;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      tx_din_d   = tx_din_q;
      overflow_d = wr & full;

      if (push) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end

      if (push && !pop) begin
         count_d = count_q + (ADDR_W+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (ADDR_W+1)'(1);
      end

      case (state_q)
         IDLE: begin
            if (pop) begin
               tx_din_d = mem[rd_ptr_q];
               rd_ptr_d = rd_ptr_q + ADDR_W'(1);
               state_d  = START;
            end
         end
         START: state_d = WAIT;
         WAIT: begin
            if (tx_done_tick) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         tx_din_q   <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         tx_din_q   <= tx_din_d;
      end
   end

   // Storage carries no reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= w_data;
      end
   end

   assign count    = count_q;
   assign overflow = overflow_q;
   assign tx_din   = tx_din_q;
   assign tx_start = (state_q == START);
   assign busy     = (state_q != IDLE) | ~empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: queue-based reference model checked every cycle,
// a simple transmitter stand-in producing done ticks, and directed scenarios.
module tb_uart_tx_feeder;

   localparam int DBIT   = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              wr = 1'b0;
   logic [DBIT-1:0]   w_data = '0;
   logic              tx_done_tick = 1'b0;
   logic              full, empty, overflow, tx_start, busy;
   logic [ADDR_W:0]   count;
   logic [DBIT-1:0]   tx_din;

   uart_tx_feeder #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr           (wr),
      .w_data       (w_data),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .overflow     (overflow),
      .tx_start     (tx_start),
      .tx_din       (tx_din),
      .tx_done_tick (tx_done_tick),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0] m_q[$];
   bit         m_start = 1'b0;
   bit         m_inflight = 1'b0;
   bit         m_ovf = 1'b0;
   logic [7:0] m_din = '0;

   initial begin
      bit pop_now, push_now, done_now;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_q.delete();
            m_start = 1'b0;
            m_inflight = 1'b0;
            m_ovf = 1'b0;
            m_din = '0;
         end else begin
            pop_now  = !m_inflight && (m_q.size() > 0);
            push_now = wr && (m_q.size() < DEPTH);
            done_now = tx_done_tick && m_inflight && !m_start;
            m_ovf    = wr && (m_q.size() == DEPTH);
            if (pop_now) m_din = m_q.pop_front();
            if (push_now) m_q.push_back(w_data);
            if (pop_now) begin
               m_inflight = 1'b1;
               m_start = 1'b1;
            end else begin
               m_start = 1'b0;
               if (done_now) m_inflight = 1'b0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int         n_cmp_c = 0;
   int         n_bad_c = 0;
   logic [7:0] launch_log[$];
   int         full_cycles = 0;

   task automatic cchk(input string nm, input int act, input int exp_v);
      n_cmp_c++;
      if (act != exp_v) begin
         n_bad_c++;
         $display("FAIL %s t=%0t: got %0d, want %0d", nm, $time, act, exp_v);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cchk("model_count",    int'(count),    m_q.size());
         cchk("model_empty",    int'(empty),    int'(m_q.size() == 0));
         cchk("model_full",     int'(full),     int'(m_q.size() == DEPTH));
         cchk("model_overflow", int'(overflow), int'(m_ovf));
         cchk("model_tx_start", int'(tx_start), int'(m_start));
         cchk("model_tx_din",   int'(tx_din),   int'(m_din));
         cchk("model_busy",     int'(busy),     int'(m_inflight || m_q.size() > 0));
         if (tx_start) launch_log.push_back(tx_din);
         if (full) full_cycles++;
      end
   end

   // ---------------- transmitter stand-in ----------------
   int frame_len = 3;
   bit rand_frames = 1'b0;
   bit xmit_en = 1'b0;
   int manual_req = 0;
   int manual_seen = 0;
   int remaining = 0;

   initial begin
      forever begin
         @(posedge clk);
         #2;
         tx_done_tick = 1'b0;
         if (reset) begin
            remaining = 0;
         end else if (manual_req != manual_seen) begin
            manual_seen++;
            tx_done_tick = 1'b1;
         end else if (tx_start && xmit_en) begin
            remaining = rand_frames ? int'($urandom_range(1, 4)) : frame_len;
         end else if (remaining > 0) begin
            remaining--;
            if (remaining == 0) tx_done_tick = 1'b1;
         end
      end
   end

   // ---------------- directed scenarios ----------------
   int n_cmp_m = 0;
   int n_bad_m = 0;

   task automatic lchk(input string nm, input int act, input int exp_v);
      n_cmp_m++;
      if (act != exp_v) begin
         n_bad_m++;
         $display("FAIL %s t=%0t: got %0d, want %0d", nm, $time, act, exp_v);
      end
   endtask

   task automatic drive(input bit w, input logic [7:0] d);
      @(posedge clk);
      #1;
      wr = w;
      w_data = d;
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while ((m_q.size() != 0 || m_inflight) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      lchk({nm, "_drain_timeout"}, int'(n >= 2000), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int fc;
      int guard;
      logic [7:0] wrap_exp[40];
      int total_cmp, total_bad;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      lchk("rst_count", int'(count), 0);
      lchk("rst_empty", int'(empty), 1);
      lchk("rst_full", int'(full), 0);
      lchk("rst_busy", int'(busy), 0);
      lchk("rst_tx_start", int'(tx_start), 0);

      // single byte
      xmit_en = 1'b1;
      frame_len = 4;
      base = launch_log.size();
      drive(1'b1, 8'hA5);
      drive(1'b0, 8'h00);
      @(negedge clk);
      lchk("single_count", int'(count), 1);
      lchk("single_start_early", int'(tx_start), 0);
      @(negedge clk);
      lchk("single_start", int'(tx_start), 1);
      lchk("single_din", int'(tx_din), 8'hA5);
      @(negedge clk);
      lchk("single_start_once", int'(tx_start), 0);
      wait_drain("single");
      @(negedge clk);
      lchk("single_busy_after", int'(busy), 0);
      lchk("single_launches", launch_log.size() - base, 1);

      // burst of 16 bytes while transmitting
      frame_len = 5;
      base = launch_log.size();
      fc = full_cycles;
      for (int i = 0; i < 16; i++) drive(1'b1, 8'(i));
      drive(1'b0, 8'h00);
      wait_drain("burst");
      lchk("burst_launches", launch_log.size() - base, 16);
      lchk("burst_full_never", full_cycles - fc, 0);
      for (int i = 0; i < 16; i++) lchk("burst_order", int'(launch_log[base + i]), i);

      // overflow with transmitter stalled
      xmit_en = 1'b0;
      base = launch_log.size();
      for (int i = 0; i < 18; i++) drive(1'b1, 8'(8'h40 + i));
      drive(1'b0, 8'h00);
      @(negedge clk);
      lchk("ovf_pulse", int'(overflow), 1);
      lchk("ovf_count", int'(count), 16);
      lchk("ovf_full", int'(full), 1);
      lchk("ovf_launched", launch_log.size() - base, 1);
      @(negedge clk);
      lchk("ovf_pulse_end", int'(overflow), 0);
      lchk("ovf_count_hold", int'(count), 16);
      xmit_en = 1'b1;
      frame_len = 2;
      manual_req++;
      wait_drain("ovf");
      lchk("ovf_launches", launch_log.size() - base, 17);
      for (int i = 0; i < 17; i++) lchk("ovf_order", int'(launch_log[base + i]), 8'h40 + i);

      // push in the same cycle as a pop from IDLE with count=3
      xmit_en = 1'b0;
      base = launch_log.size();
      for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h60 + i));
      drive(1'b0, 8'h00);
      @(negedge clk);
      lchk("simul_count_pre", int'(count), 3);
      xmit_en = 1'b1;
      frame_len = 3;
      manual_req++;
      drive(1'b0, 8'h00);
      drive(1'b1, 8'h64);
      drive(1'b0, 8'h00);
      @(negedge clk);
      lchk("simul_count", int'(count), 3);
      lchk("simul_start", int'(tx_start), 1);
      lchk("simul_din", int'(tx_din), 8'h61);
      wait_drain("simul");
      lchk("simul_launches", launch_log.size() - base, 5);
      for (int i = 1; i < 5; i++) lchk("simul_order", int'(launch_log[base + i]), 8'h60 + i);

      // pointer wrap with random gaps and frame lengths
      rand_frames = 1'b1;
      base = launch_log.size();
      for (int i = 0; i < 40; i++) wrap_exp[i] = 8'($urandom);
      for (int i = 0; i < 40; i++) begin
         guard = 0;
         drive(1'b0, 8'h00);
         while (m_q.size() >= DEPTH - 1 && guard < 200) begin
            drive(1'b0, 8'h00);
            guard++;
         end
         drive(1'b1, wrap_exp[i]);
         repeat ($urandom_range(0, 3)) drive(1'b0, 8'h00);
      end
      drive(1'b0, 8'h00);
      wait_drain("wrap");
      lchk("wrap_launches", launch_log.size() - base, 40);
      for (int i = 0; i < 40; i++) lchk("wrap_order", int'(launch_log[base + i]), int'(wrap_exp[i]));

      // asynchronous reset in WAIT with count=5
      rand_frames = 1'b0;
      xmit_en = 1'b0;
      base = launch_log.size();
      for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h70 + i));
      drive(1'b0, 8'h00);
      @(negedge clk);
      lchk("rstw_count_pre", int'(count), 5);
      lchk("rstw_busy_pre", int'(busy), 1);
      #2 reset = 1'b1;
      #1;
      lchk("rstw_tx_start", int'(tx_start), 0);
      lchk("rstw_count", int'(count), 0);
      lchk("rstw_empty", int'(empty), 1);
      lchk("rstw_busy", int'(busy), 0);
      @(negedge clk);
      #1 reset = 1'b0;
      repeat (6) @(negedge clk);
      lchk("rstw_no_launch", launch_log.size() - base, 1);
      lchk("rstw_busy_after", int'(busy), 0);
      lchk("rstw_count_after", int'(count), 0);

      total_cmp = n_cmp_m + n_cmp_c;
      total_bad = n_bad_m + n_bad_c;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", total_cmp, total_bad);
      $finish;
   end

endmodule
